// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped BTB with 2-bit saturating direction counters,
//            combinational next-PC lookup, mispredict flush and perf pulses.
// Revision : 1.0
// ============================================================================
module branch_predictor #(
  parameter int PC_W     = 16,
  parameter int IDX_BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic            pred_btb_hit,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  input  logic            upd_btb_hit,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            inc_br_cnt,
  output logic            inc_hit_cnt,
  output logic            inc_mispr_cnt
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam int TAG_W = PC_W - IDX_BITS;

  logic [DEPTH-1:0] r_valid;
  logic [1:0]       r_ctr    [DEPTH];
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [PC_W-1:0]  r_target [DEPTH];

  logic [IDX_BITS-1:0] w_f_idx;
  logic [TAG_W-1:0]    w_f_tag;
  logic [IDX_BITS-1:0] w_u_idx;
  logic [TAG_W-1:0]    w_u_tag;
  logic                w_u_hit;
  logic                w_mispr;
  logic [PC_W-1:0]     w_fetch_seq;
  logic [PC_W-1:0]     w_upd_seq;

  assign w_f_idx     = fetch_pc[IDX_BITS-1:0];
  assign w_f_tag     = fetch_pc[PC_W-1:IDX_BITS];
  assign w_u_idx     = upd_pc[IDX_BITS-1:0];
  assign w_u_tag     = upd_pc[PC_W-1:IDX_BITS];
  assign w_fetch_seq = fetch_pc + PC_W'(1);
  assign w_upd_seq   = upd_pc + PC_W'(1);

  // Lookup reads the array directly, so a same-cycle update is not bypassed.
  assign pred_btb_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign pred_taken   = pred_btb_hit && r_ctr[w_f_idx][1];
  assign pred_target  = pred_taken ? r_target[w_f_idx] : w_fetch_seq;

  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_mispr = (upd_taken != upd_pred_taken) ||
                   (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));

  assign flush       = upd_valid && w_mispr;
  assign redirect_pc = upd_taken ? upd_target : w_upd_seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (w_u_hit) begin
        if (upd_taken) begin
          if (r_ctr[w_u_idx] != 2'b11) r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'b01;
        end else begin
          if (r_ctr[w_u_idx] != 2'b00) r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        r_valid[w_u_idx] <= 1'b1;
        r_ctr[w_u_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target need no reset: they are only observed through a set valid bit.
  // On a taken hit the tag rewrite is a no-op, so hit and allocate share a path.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_br_cnt    <= 1'b0;
      inc_hit_cnt   <= 1'b0;
      inc_mispr_cnt <= 1'b0;
    end else begin
      inc_br_cnt    <= upd_valid;
      inc_hit_cnt   <= upd_valid && upd_btb_hit;
      inc_mispr_cnt <= flush;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed self-checking bench for branch_predictor.
// Revision : 1.0
// ============================================================================
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fetch_pc = 16'h0010;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        pred_btb_hit;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [15:0] upd_pred_target = '0;
  logic        upd_btb_hit = 1'b0;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        inc_br_cnt;
  logic        inc_hit_cnt;
  logic        inc_mispr_cnt;

  int n_pass = 0;
  int n_total = 0;

  branch_predictor #(.PC_W(16), .IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_btb_hit(pred_btb_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_btb_hit(upd_btb_hit),
    .flush(flush), .redirect_pc(redirect_pc), .inc_br_cnt(inc_br_cnt),
    .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                           input logic ptk, input logic [15:0] ptgt, input logic hit);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt; upd_btb_hit = hit;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_pc = 16'h0010; upd_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_total++;
    if ({pred_btb_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 16'h0011})
      $display("FAIL reset_lookup: got hit=%b tk=%b tgt=%h, need 0 0 0011", pred_btb_hit, pred_taken, pred_target);
    else n_pass++;
    n_total++;
    if ({inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, flush} !== 4'b0000)
      $display("FAIL reset_pulses: got br/hit/mis/flush=%b%b%b%b, need 0000", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, flush);
    else n_pass++;
  endtask

  task automatic test_allocate();
    drive_upd(16'h0013, 1'b1, 16'h0040, 1'b0, 16'h0014, 1'b0);
    #1;
    n_total++;
    if ({flush, redirect_pc} !== {1'b1, 16'h0040})
      $display("FAIL alloc_flush: got flush=%b redir=%h, need 1 0040", flush, redirect_pc);
    else n_pass++;
    tick();
    upd_valid = 1'b0;
    fetch_pc = 16'h0013;
    n_total++;
    if ({inc_br_cnt, inc_hit_cnt, inc_mispr_cnt} !== 3'b101)
      $display("FAIL alloc_pulses: got br/hit/mis=%b%b%b, need 101", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt);
    else n_pass++;
    #1;
    n_total++;
    if ({pred_btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 16'h0040})
      $display("FAIL alloc_lookup: got hit=%b tk=%b tgt=%h, need 1 1 0040", pred_btb_hit, pred_taken, pred_target);
    else n_pass++;
    tick();
    n_total++;
    if ({inc_br_cnt, inc_hit_cnt, inc_mispr_cnt} !== 3'b000)
      $display("FAIL pulse_one_cycle: got br/hit/mis=%b%b%b, need 000", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt);
    else n_pass++;
  endtask

  task automatic test_not_taken_sat();
    drive_upd(16'h0013, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1);
    #1;
    n_total++;
    if ({flush, redirect_pc} !== {1'b1, 16'h0014})
      $display("FAIL nt_flush: got flush=%b redir=%h, need 1 0014", flush, redirect_pc);
    else n_pass++;
    tick();
    drive_upd(16'h0013, 1'b0, 16'h0000, 1'b0, 16'h0014, 1'b1);
    #1;
    n_total++;
    if ({inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, flush} !== 4'b1110)
      $display("FAIL nt_pulses1: got br/hit/mis/flush=%b%b%b%b, need 1110", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, flush);
    else n_pass++;
    tick();
    upd_valid = 1'b0;
    fetch_pc = 16'h0013;
    n_total++;
    if ({inc_br_cnt, inc_hit_cnt, inc_mispr_cnt} !== 3'b110)
      $display("FAIL nt_pulses2: got br/hit/mis=%b%b%b, need 110", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt);
    else n_pass++;
    #1;
    n_total++;
    if ({pred_btb_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 16'h0014})
      $display("FAIL nt_lookup: got hit=%b tk=%b tgt=%h, need 1 0 0014", pred_btb_hit, pred_taken, pred_target);
    else n_pass++;
    // Two more decrements must hold at 00; one taken then reaches only 01.
    for (int i = 0; i < 2; i++) begin
      drive_upd(16'h0013, 1'b0, 16'h0000, 1'b0, 16'h0014, 1'b1);
      tick();
    end
    drive_upd(16'h0013, 1'b1, 16'h0040, 1'b0, 16'h0014, 1'b1);
    tick();
    upd_valid = 1'b0;
    #1;
    n_total++;
    if ({pred_btb_hit, pred_taken} !== 2'b10)
      $display("FAIL nt_saturate: got hit=%b tk=%b, need 1 0", pred_btb_hit, pred_taken);
    else n_pass++;
  endtask

  task automatic test_taken_sat();
    // ctr=01 -> four increments saturate at 11, one decrement -> 10
    for (int i = 0; i < 4; i++) begin
      drive_upd(16'h0013, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b1);
      #1;
      n_total++;
      if (flush !== 1'b0)
        $display("FAIL correct_no_flush[%0d]: got flush=%b, need 0", i, flush);
      else n_pass++;
      tick();
    end
    drive_upd(16'h0013, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1);
    tick();
    upd_valid = 1'b0;
    fetch_pc = 16'h0013;
    #1;
    n_total++;
    if ({pred_btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 16'h0040})
      $display("FAIL t_saturate: got hit=%b tk=%b tgt=%h, need 1 1 0040", pred_btb_hit, pred_taken, pred_target);
    else n_pass++;
    drive_upd(16'h0013, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b1);
    tick();
  endtask

  task automatic test_target_mismatch();
    drive_upd(16'h0013, 1'b1, 16'h0050, 1'b1, 16'h0040, 1'b1);
    #1;
    n_total++;
    if ({flush, redirect_pc} !== {1'b1, 16'h0050})
      $display("FAIL tgt_flush: got flush=%b redir=%h, need 1 0050", flush, redirect_pc);
    else n_pass++;
    tick();
    upd_valid = 1'b0;
    fetch_pc = 16'h0013;
    #1;
    n_total++;
    if ({inc_mispr_cnt, pred_btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 1'b1, 16'h0050})
      $display("FAIL tgt_update: got mis=%b hit=%b tk=%b tgt=%h, need 1 1 1 0050", inc_mispr_cnt, pred_btb_hit, pred_taken, pred_target);
    else n_pass++;
  endtask

  task automatic test_alias();
    drive_upd(16'h0023, 1'b1, 16'h0080, 1'b0, 16'h0024, 1'b0);
    fetch_pc = 16'h0023;
    #1;
    n_total++;
    if ({pred_btb_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 16'h0024})
      $display("FAIL alias_preupdate: got hit=%b tk=%b tgt=%h, need 0 0 0024", pred_btb_hit, pred_taken, pred_target);
    else n_pass++;
    tick();
    upd_valid = 1'b0;
    #1;
    n_total++;
    if ({pred_btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 16'h0080})
      $display("FAIL alias_postupdate: got hit=%b tk=%b tgt=%h, need 1 1 0080", pred_btb_hit, pred_taken, pred_target);
    else n_pass++;
    fetch_pc = 16'h0013;
    #1;
    n_total++;
    if ({pred_btb_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 16'h0014})
      $display("FAIL alias_evicted: got hit=%b tk=%b tgt=%h, need 0 0 0014", pred_btb_hit, pred_taken, pred_target);
    else n_pass++;
  endtask

  task automatic test_idle_and_wrap();
    upd_valid = 1'b0; upd_taken = 1'b1; upd_pred_taken = 1'b0; upd_btb_hit = 1'b1;
    fetch_pc = 16'hFFFF;
    #1;
    n_total++;
    if ({flush, pred_btb_hit, pred_target} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL idle_wrap: got flush=%b hit=%b tgt=%h, need 0 0 0000", flush, pred_btb_hit, pred_target);
    else n_pass++;
    tick();
    n_total++;
    if ({inc_br_cnt, inc_hit_cnt, inc_mispr_cnt} !== 3'b000)
      $display("FAIL idle_pulses: got br/hit/mis=%b%b%b, need 000", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt);
    else n_pass++;
    drive_upd(16'hFFFF, 1'b0, 16'h1234, 1'b1, 16'h1234, 1'b0);
    #1;
    n_total++;
    if ({flush, redirect_pc} !== {1'b1, 16'h0000})
      $display("FAIL redirect_wrap: got flush=%b redir=%h, need 1 0000", flush, redirect_pc);
    else n_pass++;
    tick();
    upd_valid = 1'b0;
    #1;
    n_total++;
    if ({pred_btb_hit, pred_target} !== {1'b0, 16'h0000})
      $display("FAIL miss_nt_nochange: got hit=%b tgt=%h, need 0 0000", pred_btb_hit, pred_target);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive_upd(16'h0023, 1'b1, 16'h0090, 1'b1, 16'h0080, 1'b1);
    fetch_pc = 16'h0023;
    tick();
    upd_valid = 1'b0;
    n_total++;
    if ({inc_br_cnt, inc_hit_cnt, inc_mispr_cnt} !== 3'b111)
      $display("FAIL pre_rst_pulses: got br/hit/mis=%b%b%b, need 111", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, pred_btb_hit, pred_target} !== {4'b0000, 16'h0024})
      $display("FAIL async_rst: got br/hit/mis=%b%b%b hit=%b tgt=%h, need 0000 0024",
               inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, pred_btb_hit, pred_target);
    else n_pass++;
    #1 rst = 1'b0;
    tick();
    // Fresh allocation after reset must start at ctr=10 (predict taken).
    drive_upd(16'h0023, 1'b1, 16'h00A0, 1'b0, 16'h0024, 1'b0);
    tick();
    upd_valid = 1'b0;
    #1;
    n_total++;
    if ({pred_btb_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 16'h00A0})
      $display("FAIL post_rst_alloc: got hit=%b tk=%b tgt=%h, need 1 1 00A0", pred_btb_hit, pred_taken, pred_target);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_not_taken_sat();
    test_taken_sat();
    test_target_mismatch();
    test_alias();
    test_idle_and_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating direction counters.
- Sits in the fetch stage. It supplies the next-PC prediction each cycle and resolves branches reported back from execute.
- On resolution it generates the redirect/flush and the event pulses that feed the memory-mapped performance counters (branch, hit, mispredict).

Parameters:
PC_W, 16, PC and target width in bits (word-addressed).
IDX_BITS, 4, index width; BTB depth is 2**IDX_BITS entries.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous reset, active-high.
fetch_pc  input  PC_W  PC being fetched this cycle.
pred_taken  output  1  prediction for fetch_pc (combinational).
pred_target  output  PC_W  predicted next PC (combinational).
pred_btb_hit  output  1  fetch_pc matched a valid BTB entry (combinational).
upd_valid  input  1  execute stage is resolving a branch this cycle.
upd_pc  input  PC_W  PC of the resolving branch.
upd_taken  input  1  actual direction.
upd_target  input  PC_W  actual taken target.
upd_pred_taken  input  1  prediction carried down the pipe with this branch.
upd_pred_target  input  PC_W  predicted next PC carried with this branch.
upd_btb_hit  input  1  pred_btb_hit carried with this branch.
flush  output  1  mispredict; pipeline must squash younger instructions (combinational).
redirect_pc  output  PC_W  correct next PC when flush=1.
inc_br_cnt  output  1  one-cycle pulse per resolved branch.
inc_hit_cnt  output  1  one-cycle pulse per resolved branch with upd_btb_hit=1.
inc_mispr_cnt  output  1  one-cycle pulse per mispredicted branch.

Behaviour:
- Storage per entry:
  - valid (1 bit)
  - tag (PC_W-IDX_BITS bits)
  - target (PC_W bits)
  - ctr (2 bits)
- Addressing: idx = pc[IDX_BITS-1:0]; tag = pc[PC_W-1:IDX_BITS].
- Reset (async, any time including mid-update): every entry valid=0, ctr=2'b01 (weakly not-taken); inc_* outputs = 0. flush and redirect_pc follow their inputs with no reset dependence.
- Lookup (zero latency, combinational):
  - pred_btb_hit = valid[idx] & (tag[idx]==fetch_pc tag).
  - pred_taken = pred_btb_hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : fetch_pc+1 (mod 2**PC_W; 16'hFFFF+1 = 16'h0000).
- Mispredict (combinational, only when upd_valid=1):
  - mispr = (upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)).
  - flush = upd_valid & mispr.
  - redirect_pc = upd_taken ? upd_target : upd_pc+1.
  - With upd_valid=0, flush=0 and redirect_pc is don't-care.
- Table update (rising edge, when upd_valid=1), with m = entry at upd_pc idx:
  - Tag match & valid, taken: ctr = sat_inc(ctr) (11 stays 11); target = upd_target.
  - Tag match & valid, not-taken: ctr = sat_dec(ctr) (00 stays 00); target unchanged.
  - Miss, taken: allocate/replace: valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss, not-taken: no change.
- Counter pulses: registered, asserted exactly one cycle after the upd_valid cycle, and held high for one cycle only.
  - inc_br_cnt = upd_valid.
  - inc_hit_cnt = upd_valid & upd_btb_hit.
  - inc_mispr_cnt = flush.
  - Back-to-back upd_valid cycles give back-to-back pulses.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents (no write-through bypass); the new value is visible the following cycle.
- No handshake: update is single-cycle and always accepted. The execute stage guarantees at most one resolving branch per cycle.

Test Plan:
1. Reset, then fetch_pc=16'h0010 -> pred_btb_hit=0, pred_taken=0, pred_target=16'h0011; inc_* = 0.
2. Taken branch resolved at upd_pc=16'h0013, upd_target=16'h0040, upd_pred_taken=0 -> same cycle flush=1, redirect_pc=16'h0040. Next cycle inc_br_cnt=1, inc_mispr_cnt=1, inc_hit_cnt=0. Subsequent fetch_pc=16'h0013 -> pred_btb_hit=1, pred_taken=1 (ctr=10), pred_target=16'h0040.
3. Resolve that branch not-taken twice with upd_btb_hit=1 -> ctr 10->01->00. The first resolution (pred_taken=1) gives flush=1, redirect_pc=16'h0014. Lookup then gives pred_taken=0, pred_target=16'h0014. inc_hit_cnt pulses twice. Two further not-taken updates leave ctr at 00 (saturation).
4. Four taken updates on a hit entry -> ctr saturates at 11; one not-taken then leaves pred_taken=1 (ctr=10).
5. Alias: upd_pc=16'h0023 taken to 16'h0080 evicts the 16'h0013 entry -> fetch_pc=16'h0013 gives pred_btb_hit=0. Also the same-cycle fetch_pc=16'h0023 during that update shows pre-update data, and shows the new data next cycle.
6. Target mismatch: hit, ctr=11, upd_taken=1, upd_target=16'h0050 vs pred 16'h0040 -> flush=1, redirect_pc=16'h0050, target updated. Finally, assert rst mid-stream -> all entries invalid and inc_* = 0 immediately.
